// File: rtl/edge_event_arbiter.sv
// -----------------------------------------------------------------------------
// edge_event_arbiter
//
// Watches NUM_CH level inputs for qualified rising and/or falling edges. Each
// edge is held in a per-channel pending flag. A round-robin arbiter presents
// pending events one at a time on a valid/ready interface. If a second edge
// arrives before the first is consumed, the event is recorded as lost in a
// sticky per-channel overflow flag.
//
// Build option:
//   EDGE_EVENT_ARB_SYNC_EN  When defined, each sig_in bit passes through a
//                           two-flop synchronizer before edge detection. This
//                           adds two cycles of latency. When undefined, sig_in
//                           feeds the edge detector directly.
//
// Parameters:
//   NUM_CH  number of monitored channels (2..16)
//   ID_W    width of evt_id; must equal clog2(NUM_CH)
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   sig_in     per-channel level inputs
//   ch_en      per-channel enable (disabled: edges ignored, pending cleared)
//   mode_rise  per-channel: rising edges generate events
//   mode_fall  per-channel: falling edges generate events
//   evt_valid  an event is presented
//   evt_ready  consumer accepts the presented event
//   evt_id     channel index of the presented event
//   evt_rise   1 = presented event was a rising edge, 0 = falling edge
//   pending    per-channel pending-event flags
//   overflow   per-channel sticky lost-event flags
//   clr_ovf    single-cycle pulse that clears all overflow flags
// -----------------------------------------------------------------------------
module edge_event_arbiter #(
    parameter int NUM_CH = 4,
    parameter int ID_W   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] sig_in,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic [NUM_CH-1:0] mode_rise,
    input  logic [NUM_CH-1:0] mode_fall,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [ID_W-1:0]   evt_id,
    output logic              evt_rise,
    output logic [NUM_CH-1:0] pending,
    output logic [NUM_CH-1:0] overflow,
    input  logic              clr_ovf
);

    typedef enum logic {IDLE, PRESENT} state_t;

    state_t            state_q, state_d;
    logic [NUM_CH-1:0] s;
    logic [NUM_CH-1:0] dly_q;
    logic [NUM_CH-1:0] rise, fall, qual;
    logic [NUM_CH-1:0] pending_q, pending_d;
    logic [NUM_CH-1:0] type_q, type_d;
    logic [NUM_CH-1:0] ovf_q, ovf_d;
    logic [NUM_CH-1:0] acc_mask;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   evt_id_q, evt_id_d;
    logic              evt_rise_q, evt_rise_d;
    logic [ID_W-1:0]   grant_id;
    logic              accept;

    // Return the first requesting channel, searching upward from ptr and
    // wrapping at NUM_CH-1. The result is only used when req is non-zero.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_CH-1:0] req,
                                                input logic [ID_W-1:0]   ptr);
        logic [ID_W-1:0] pick;
        logic [ID_W-1:0] cand;
        logic            found;
        int              idx;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            cand = ID_W'(idx);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

`ifdef EDGE_EVENT_ARB_SYNC_EN
    logic [NUM_CH-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sig_in;
            sync2_q <= sync1_q;
        end
    end

    assign s = sync2_q;
`else
    assign s = sig_in;
`endif

    // dly_q resets to 0, so an input that is already high after reset
    // release is reported as a rising edge.
    assign rise = s & ~dly_q;
    assign fall = ~s & dly_q;
    assign qual = ch_en & ((rise & mode_rise) | (fall & mode_fall));

    assign accept   = (state_q == PRESENT) && evt_ready;
    assign grant_id = rr_pick(pending_q, rr_ptr_q);

    always_comb begin
        acc_mask = '0;
        if (accept) acc_mask[evt_id_q] = 1'b1;
    end

    // Per-channel bookkeeping. A new edge takes priority over acceptance, so
    // an edge arriving in the acceptance cycle survives as a fresh event.
    // It is counted as a loss only if the old event is still unconsumed.
    always_comb begin
        pending_d = pending_q;
        type_d    = type_q;
        ovf_d     = ovf_q & ~{NUM_CH{clr_ovf}};
        for (int i = 0; i < NUM_CH; i++) begin
            if (qual[i]) begin
                type_d[i] = rise[i];
                if (pending_q[i] && !acc_mask[i]) ovf_d[i] = 1'b1;
            end
            if (!ch_en[i])        pending_d[i] = 1'b0;
            else if (qual[i])     pending_d[i] = 1'b1;
            else if (acc_mask[i]) pending_d[i] = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        evt_id_d   = evt_id_q;
        evt_rise_d = evt_rise_q;
        rr_ptr_d   = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (|pending_q) begin
                    state_d    = PRESENT;
                    evt_id_d   = grant_id;
                    evt_rise_d = type_q[grant_id];
                end
            end
            PRESENT: begin
                if (evt_ready) begin
                    state_d  = IDLE;
                    rr_ptr_d = (evt_id_q == ID_W'(NUM_CH - 1)) ? '0
                                                               : evt_id_q + ID_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            dly_q      <= '0;
            pending_q  <= '0;
            type_q     <= '0;
            ovf_q      <= '0;
            rr_ptr_q   <= '0;
            evt_id_q   <= '0;
            evt_rise_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dly_q      <= s;
            pending_q  <= pending_d;
            type_q     <= type_d;
            ovf_q      <= ovf_d;
            rr_ptr_q   <= rr_ptr_d;
            evt_id_q   <= evt_id_d;
            evt_rise_q <= evt_rise_d;
        end
    end

    assign evt_valid = (state_q == PRESENT);
    assign evt_id    = evt_id_q;
    assign evt_rise  = evt_rise_q;
    assign pending   = pending_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// -----------------------------------------------------------------------------
// tb_edge_event_arbiter
//
// Directed testbench for edge_event_arbiter with NUM_CH = 4. Each expected
// value is computed by hand from the edge, pending, arbitration and overflow
// rules. In the synchronizer build, the extra SYNC_LAT cycles are inserted
// before every edge-dependent check.
// -----------------------------------------------------------------------------
module tb_edge_event_arbiter;

    localparam int NUM_CH = 4;
    localparam int ID_W   = 2;
`ifdef EDGE_EVENT_ARB_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NUM_CH-1:0] sig_in, ch_en, mode_rise, mode_fall;
    logic              evt_valid, evt_ready, evt_rise, clr_ovf;
    logic [ID_W-1:0]   evt_id;
    logic [NUM_CH-1:0] pending, overflow;

    int checks   = 0;
    int failures = 0;

    edge_event_arbiter #(.NUM_CH(NUM_CH), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sig_in    (sig_in),
        .ch_en     (ch_en),
        .mode_rise (mode_rise),
        .mode_fall (mode_fall),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_id    (evt_id),
        .evt_rise  (evt_rise),
        .pending   (pending),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Clock until an input change applied now has reached pending.
    task automatic settle();
        repeat (SYNC_LAT + 1) tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        sig_in    = '0;
        ch_en     = 4'hF;
        mode_rise = 4'hF;
        mode_fall = 4'h0;
        evt_ready = 1'b0;
        clr_ovf   = 1'b0;

        // Reset state
        #3;
        check_eq("rst_valid",   32'(evt_valid), 32'd0);
        check_eq("rst_id",      32'(evt_id),    32'd0);
        check_eq("rst_rise",    32'(evt_rise),  32'd0);
        check_eq("rst_pending", 32'(pending),   32'd0);
        check_eq("rst_ovf",     32'(overflow),  32'd0);
        tick();
        tick();
        #2 rst_n = 1'b1;

        // Simultaneous edges on ch0, ch1, ch3: round-robin grants 0, 1, 3
        evt_ready = 1'b1;
        sig_in    = 4'b1011;
        settle();
        check_eq("rr_pend", 32'(pending), 32'hB);
        check_eq("rr_idle", 32'(evt_valid), 32'd0);
        begin
            logic [ID_W-1:0] order [3];
            order[0] = 2'd0;
            order[1] = 2'd1;
            order[2] = 2'd3;
            for (int b = 0; b < 2; b++) begin
                if (b == 1) begin
                    sig_in = 4'b0000;
                    settle();
                    tick();
                    check_eq("rr_fall_none", 32'(pending), 32'd0);
                    sig_in = 4'b1011;
                    settle();
                end
                for (int g = 0; g < 3; g++) begin
                    tick();
                    check_eq("rr_valid", 32'(evt_valid), 32'd1);
                    check_eq("rr_id",    32'(evt_id),    32'(order[g]));
                    check_eq("rr_rise",  32'(evt_rise),  32'd1);
                    tick();
                    check_eq("rr_bubble", 32'(evt_valid), 32'd0);
                end
                check_eq("rr_done", 32'(pending), 32'd0);
            end
        end

        // Single rising edge on ch2: valid two cycles after the edge
        sig_in = 4'b1111;
        settle();
        check_eq("ch2_pend",  32'(pending),   32'h4);
        check_eq("ch2_early", 32'(evt_valid), 32'd0);
        tick();
        check_eq("ch2_valid", 32'(evt_valid), 32'd1);
        check_eq("ch2_id",    32'(evt_id),    32'd2);
        check_eq("ch2_rise",  32'(evt_rise),  32'd1);
        tick();
        check_eq("ch2_acc",   32'(evt_valid), 32'd0);
        check_eq("ch2_clr",   32'(pending),   32'd0);

        // Overflow on ch1 while its event waits; then clear; then set-wins
        evt_ready = 1'b0;
        sig_in    = 4'b1101;
        settle();
        sig_in = 4'b1111;
        settle();
        tick();
        check_eq("ov_valid", 32'(evt_valid), 32'd1);
        check_eq("ov_id",    32'(evt_id),    32'd1);
        sig_in = 4'b1101;
        settle();
        check_eq("ov_fall_none", 32'(overflow), 32'd0);
        sig_in = 4'b1111;
        settle();
        check_eq("ov_set",  32'(overflow),  32'h2);
        check_eq("ov_pend", 32'(pending),   32'h2);
        check_eq("ov_hold", 32'(evt_id),    32'd1);
        check_eq("ov_vld",  32'(evt_valid), 32'd1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check_eq("ov_clr", 32'(overflow), 32'd0);
        sig_in = 4'b1101;
        settle();
        sig_in = 4'b1111;
        repeat (SYNC_LAT) tick();
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check_eq("ov_setwins", 32'(overflow), 32'h2);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check_eq("ov_clr2", 32'(overflow), 32'd0);

        // New edge on ch1 in the very cycle it is accepted
        sig_in = 4'b1101;
        settle();
        sig_in = 4'b1111;
        repeat (SYNC_LAT) tick();
        evt_ready = 1'b1;
        tick();
        check_eq("accedge_vld",  32'(evt_valid), 32'd0);
        check_eq("accedge_pend", 32'(pending),   32'h2);
        check_eq("accedge_ovf",  32'(overflow),  32'd0);
        tick();
        check_eq("accedge_re", 32'(evt_valid), 32'd1);
        check_eq("accedge_id", 32'(evt_id),    32'd1);
        tick();
        check_eq("accedge_done", 32'(pending), 32'd0);

        // Falling-edge-only mode on ch0
        mode_rise = 4'h0;
        mode_fall = 4'h1;
        sig_in    = 4'b1110;
        settle();
        check_eq("fall_pend", 32'(pending), 32'h1);
        tick();
        check_eq("fall_valid", 32'(evt_valid), 32'd1);
        check_eq("fall_id",    32'(evt_id),    32'd0);
        check_eq("fall_rise",  32'(evt_rise),  32'd0);
        tick();
        check_eq("fall_acc", 32'(evt_valid), 32'd0);
        sig_in = 4'b1111;
        settle();
        check_eq("fall_norise", 32'(pending), 32'd0);
        tick();
        check_eq("fall_novld", 32'(evt_valid), 32'd0);

        // Disabling a channel clears pending but keeps the presented event
        mode_rise = 4'hF;
        mode_fall = 4'h0;
        evt_ready = 1'b0;
        sig_in    = 4'b0111;
        settle();
        sig_in = 4'b1111;
        settle();
        check_eq("dis_pend", 32'(pending), 32'h8);
        tick();
        check_eq("dis_id", 32'(evt_id), 32'd3);
        ch_en = 4'h7;
        tick();
        check_eq("dis_clr",  32'(pending),   32'd0);
        check_eq("dis_keep", 32'(evt_valid), 32'd1);
        evt_ready = 1'b1;
        tick();
        check_eq("dis_acc", 32'(evt_valid), 32'd0);
        ch_en = 4'hF;
        tick();
        check_eq("dis_quiet", 32'(evt_valid), 32'd0);

        // Asynchronous reset during a held presentation with overflow
        evt_ready = 1'b0;
        sig_in    = 4'b1110;
        settle();
        sig_in = 4'b1111;
        settle();
        tick();
        check_eq("ar_valid", 32'(evt_valid), 32'd1);
        sig_in = 4'b1110;
        settle();
        sig_in = 4'b1111;
        settle();
        check_eq("ar_ovf", 32'(overflow), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("ar_drop",  32'(evt_valid), 32'd0);
        check_eq("ar_pend",  32'(pending),   32'd0);
        check_eq("ar_ovf0",  32'(overflow),  32'd0);
        tick();
        #2 rst_n = 1'b1;
        #1;
        check_eq("ar_rel_pend", 32'(pending),  32'd0);
        check_eq("ar_rel_ovf",  32'(overflow), 32'd0);

        // Inputs already high at release appear as rising edges
        settle();
        check_eq("post_pend", 32'(pending), 32'hF);
        tick();
        check_eq("post_valid", 32'(evt_valid), 32'd1);
        check_eq("post_id",    32'(evt_id),    32'd0);
        check_eq("post_rise",  32'(evt_rise),  32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/edge_event_arbiter.md
EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

Interface
REQ-001 Parameter NUM_CH, default 4, number of monitored input channels (2..16).
REQ-002 Parameter ID_W, default 2, width of evt_id; SHALL equal clog2(NUM_CH).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 sig_in  input  NUM_CH  per-channel level inputs to monitor.
REQ-006 ch_en  input  NUM_CH  per-channel enable; 0 = edges ignored, pending cleared.
REQ-007 mode_rise  input  NUM_CH  per-channel: 1 = rising edges generate events.
REQ-008 mode_fall  input  NUM_CH  per-channel: 1 = falling edges generate events.
REQ-009 evt_valid  output  1  event presented.
REQ-010 evt_ready  input  1  consumer accepts event when high with evt_valid.
REQ-011 evt_id  output  ID_W  channel index of presented event.
REQ-012 evt_rise  output  1  1 = presented event was rising edge, 0 = falling.
REQ-013 pending  output  NUM_CH  per-channel pending-event flags.
REQ-014 overflow  output  NUM_CH  per-channel sticky lost-event flags.
REQ-015 clr_ovf  input  1  single-cycle pulse; clears all overflow bits.

Function
REQ-016 Per channel: one delay flop dly holds previous sample; rise = s & ~dly, fall = ~s & dly, s = sig_in (or synchronized, see Configuration).
REQ-017 Qualified edge = ch_en & ((rise & mode_rise) | (fall & mode_fall)); sets pending and records edge type (1 rise, 0 fall) at next clock edge.
REQ-018 Qualified edge on a channel already pending and not being accepted this cycle: overflow bit set, edge type overwritten with newest, pending stays 1.
REQ-019 Qualified edge in same cycle as acceptance of that channel: pending remains 1 with new type, overflow not set.
REQ-020 ch_en low: pending bit of that channel cleared each cycle; overflow bit unaffected.
REQ-021 FSM states IDLE, PRESENT; IDLE -> PRESENT when any pending bit is 1; PRESENT -> IDLE on evt_valid & evt_ready.
REQ-022 On IDLE -> PRESENT: round-robin grant starting from index rr_ptr upward, wrapping NUM_CH-1 -> 0; winner's id and type latched into evt_id/evt_rise.
REQ-023 evt_valid = 1 exactly in PRESENT; evt_id/evt_rise held stable while evt_valid & ~evt_ready.
REQ-024 On acceptance: granted channel pending cleared (subject to REQ-019), rr_ptr = granted id + 1 mod NUM_CH.
REQ-025 Presented event stays valid until accepted even if its channel is disabled meanwhile.
REQ-026 Latency without sync: sig_in change set up before clock edge k -> pending high after edge k -> evt_valid high after edge k+1.
REQ-027 Throughput: max one event per two cycles (one IDLE bubble after each acceptance).
REQ-028 clr_ovf coincident with new overflow on a channel: that bit ends set (set wins).

Reset
REQ-029 rst_n low: dly=0, sync flops=0, pending=0, types=0, overflow=0, rr_ptr=0, state IDLE, evt_valid=0, evt_id=0, evt_rise=0.
REQ-030 Reset mid-presentation SHALL drop evt_valid immediately (asynchronous); event lost, no overflow recorded.
REQ-031 After reset release, a channel whose s is already 1 SHALL produce a rising edge on first cycle (dly reset to 0).

Configuration
REQ-032 Macro EDGE_EVENT_ARB_SYNC_EN defined: two-flop synchronizer per channel ahead of dly, latency REQ-026 increased by 2 cycles; undefined: sig_in feeds edge logic directly.

Verification
REQ-033 NUM_CH=4, mode_rise=4'hF, ch_en=4'hF, sig_in[2] 0->1, evt_ready=1 -> evt_valid high 2 cycles later, evt_id=2, evt_rise=1, pending[2] clears after accept.
REQ-034 Rising edges on ch0,1,3 same cycle, evt_ready=1 -> grants in order 0,1,3, each 2 cycles apart; next simultaneous batch starts at ch0 after rr_ptr wraps past 3 -> 0.
REQ-035 evt_ready=0, two rising edges on ch1 separated by falling edge with mode_fall[1]=0 -> overflow[1]=1, pending[1]=1; clr_ovf pulse -> overflow[1]=0.
REQ-036 mode_fall[0]=1 only, sig_in[0] 1->0 -> evt_rise=0; 0->1 -> no event.
REQ-037 rst_n asserted while evt_valid=1 and evt_ready=0 -> evt_valid=0 same instant; all pending/overflow 0 after release.
REQ-038 Build with EDGE_EVENT_ARB_SYNC_EN, repeat REQ-033 -> evt_valid high 4 cycles after edge.
